// File: rtl/uart_rx_fifo.sv
// Receive byte FIFO between UART receiver and register block; pushes on each rising edge of rx_byte_ready.
// Latency: rd_data registered on pop (UART_RX_FIFO_FWFT_EN gives combinational head). Backpressure: none, drops when full and sets overflow.
module uart_rx_fifo #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        rx_byte,
    input  logic              rx_byte_ready,
    input  logic              pop,
    output logic [7:0]        rd_data,
    output logic              empty,
    output logic              full,
    output logic [ADDR_W:0]   count,
    output logic              overflow,
    input  logic              clr_overflow
);

    localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH);

    logic [7:0]        mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic              rdy_q;
    logic              push;
    logic              do_push;
    logic              do_pop;
    logic              drop;
    logic [ADDR_W:0]   count_nxt;

    // A pop in the same cycle frees the slot, so a push at full is still accepted.
    assign push    = rx_byte_ready & ~rdy_q;
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign drop    = push & full & ~do_pop;

    always_comb begin
        count_nxt = count;
        if (do_push && !do_pop)
            count_nxt = count + (ADDR_W+1)'(1);
        else if (do_pop && !do_push)
            count_nxt = count - (ADDR_W+1)'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            empty    <= 1'b1;
            full     <= 1'b0;
            overflow <= 1'b0;
            rdy_q    <= 1'b1;
        end else begin
            rdy_q <= rx_byte_ready;
            if (do_push)
                wr_ptr <= wr_ptr + ADDR_W'(1);
            if (do_pop)
                rd_ptr <= rd_ptr + ADDR_W'(1);
            count <= count_nxt;
            empty <= (count_nxt == '0);
            full  <= (count_nxt == FULL_CNT);
            if (drop)
                overflow <= 1'b1;
            else if (clr_overflow)
                overflow <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr] <= rx_byte;
    end

`ifdef UART_RX_FIFO_FWFT_EN
    assign rd_data = empty ? 8'h00 : mem[rd_ptr];
`else
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            rd_data <= 8'h00;
        else if (do_pop)
            rd_data <= mem[rd_ptr];
    end
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo with a queue scoreboard of expected read bytes.
module tb_uart_rx_fifo;

    localparam int DEPTH  = 16;
    localparam int ADDR_W = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic [7:0]        rx_byte = 8'h00;
    logic              rx_byte_ready = 1'b0;
    logic              pop = 1'b0;
    logic [7:0]        rd_data;
    logic              empty;
    logic              full;
    logic [ADDR_W:0]   count;
    logic              overflow;
    logic              clr_overflow = 1'b0;

    int total  = 0;
    int passed = 0;
    int cnt_m  = 0;
    logic [7:0] exp_q[$];

    uart_rx_fifo #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk           (clk),
        .rst           (rst),
        .rx_byte       (rx_byte),
        .rx_byte_ready (rx_byte_ready),
        .pop           (pop),
        .rd_data       (rd_data),
        .empty         (empty),
        .full          (full),
        .count         (count),
        .overflow      (overflow),
        .clr_overflow  (clr_overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Called at a negedge with rx_byte_ready low; returns at a negedge with it low again.
    task automatic send(input logic [7:0] b, input int hold);
        rx_byte       = b;
        rx_byte_ready = 1'b1;
        repeat (hold) @(negedge clk);
        rx_byte_ready = 1'b0;
        @(negedge clk);
        if (cnt_m < DEPTH) begin
            exp_q.push_back(b);
            cnt_m++;
        end
    endtask

    task automatic do_pop(input string tag);
        logic [7:0] e;
        e = (exp_q.size() > 0) ? exp_q[0] : 8'h00;
`ifdef UART_RX_FIFO_FWFT_EN
        if (exp_q.size() > 0) chk(tag, rd_data, e);
`endif
        pop = 1'b1;
        @(negedge clk);
        pop = 1'b0;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            cnt_m--;
`ifndef UART_RX_FIFO_FWFT_EN
            chk(tag, rd_data, e);
`endif
        end
    endtask

    initial begin
        // Reset asserted mid-cycle with the ready level already high.
        #3;
        rst           = 1'b1;
        rx_byte_ready = 1'b1;
        rx_byte       = 8'hEE;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_empty", empty, 1);
        chk("reset_count", count, 0);
        chk("reset_overflow", overflow, 0);
        chk("reset_rd_data", rd_data, 0);
        chk("reset_full", full, 0);
        rx_byte_ready = 1'b0;
        @(negedge clk);
        chk("no_push_held_level", count, 0);

        // Three bytes, level held for 5 cycles each.
        send(8'h41, 5);
        send(8'h42, 5);
        send(8'h43, 5);
        chk("three_count", count, 3);
        do_pop("three_pop0");
        do_pop("three_pop1");
        do_pop("three_pop2");
        chk("three_empty", empty, 1);
        chk("three_count0", count, 0);
        pop = 1'b1;
        @(negedge clk);
        pop = 1'b0;
        chk("empty_pop_count", count, 0);
`ifndef UART_RX_FIFO_FWFT_EN
        chk("empty_pop_hold", rd_data, 8'h43);
`endif

        // Fill past capacity.
        for (int i = 0; i < 17; i++) send(8'(i), 1);
        chk("fill_full", full, 1);
        chk("fill_count", count, 16);
        chk("fill_overflow", overflow, 1);
        chk("fill_not_empty", empty, 0);
        for (int i = 0; i < 16; i++) do_pop("fill_drain");
        chk("drain_empty", empty, 1);
        chk("overflow_sticky", overflow, 1);
        clr_overflow = 1'b1;
        @(negedge clk);
        clr_overflow = 1'b0;
        chk("overflow_clear", overflow, 0);

        // Push and pop in the same cycle while full.
        for (int i = 0; i < 16; i++) send(8'(8'h80 + i), 1);
        chk("pp_full", full, 1);
        rx_byte       = 8'hAA;
        rx_byte_ready = 1'b1;
        pop           = 1'b1;
        @(negedge clk);
        pop           = 1'b0;
        rx_byte_ready = 1'b0;
`ifndef UART_RX_FIFO_FWFT_EN
        chk("pp_rd_data", rd_data, 8'h80);
`endif
        void'(exp_q.pop_front());
        exp_q.push_back(8'hAA);
        @(negedge clk);
        chk("pp_count", count, 16);
        chk("pp_overflow", overflow, 0);
        for (int i = 0; i < 16; i++) do_pop("pp_drain");
        chk("pp_empty", empty, 1);

        // Pointer wrap: one byte in, one byte out, 40 times.
        for (int i = 0; i < 40; i++) begin
            send(8'(i), 1);
            chk("wrap_count1", count, 1);
            do_pop("wrap_data");
            chk("wrap_count0", count, 0);
        end

`ifdef UART_RX_FIFO_FWFT_EN
        send(8'h5A, 2);
        chk("fwft_head", rd_data, 8'h5A);
        do_pop("fwft_pop");
        chk("fwft_empty", empty, 1);
        chk("fwft_zero", rd_data, 8'h00);
`endif

        chk("scoreboard_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
